// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multicycle main FSM (master) and the RV32I datapath (slave).
// The master modport drives every enable/select and observes the opcode and ALU zero flag.
interface multicycle_main_fsm_if;
   logic [6:0] op;
   logic       Zero;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ImmSrc;
   logic       RegWrite;
   logic [1:0] ALUOp;
   logic       Branch;
   logic       InstrRetire;
   logic       IllegalOp;

   modport master (
      input  op, Zero,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ImmSrc, RegWrite, ALUOp, Branch, InstrRetire, IllegalOp
   );

   modport slave (
      output op, Zero,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ImmSrc, RegWrite, ALUOp, Branch, InstrRetire, IllegalOp
   );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Multicycle RV32I main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Define ILLEGAL_TRAP_EN to make the ILLEGAL state a sink until reset; otherwise illegal ops retire as NOPs.
module multicycle_main_fsm #(
   parameter int MEM_WAIT = 0,
   parameter int STATE_W  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   multicycle_main_fsm_if.master ctrl,
   output logic [STATE_W-1:0]   state
);

   typedef enum logic [STATE_W-1:0] {
      FETCH    = STATE_W'(0),
      DECODE   = STATE_W'(1),
      MEMADR   = STATE_W'(2),
      MEMREAD  = STATE_W'(3),
      MEMWB    = STATE_W'(4),
      MEMWRITE = STATE_W'(5),
      EXECUTER = STATE_W'(6),
      EXECUTEI = STATE_W'(7),
      ALUWB    = STATE_W'(8),
      BEQ      = STATE_W'(9),
      JAL      = STATE_W'(10),
      LUI      = STATE_W'(11),
      ILLEGAL  = STATE_W'(12)
   } state_t;

   localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

   state_t     state_q;
   state_t     state_d;
   logic [2:0] wait_q;

   logic       pc_update;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic       reg_write;
   logic [1:0] alu_op;
   logic       branch;
   logic       retire;
   logic       illegal;

   // Wait counter sits at 0 outside MEMREAD, so it is already cleared on entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
         wait_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         if (state_q == MEMREAD) begin
            wait_q <= wait_q + 3'd1;
         end else begin
            wait_q <= 3'd0;
         end
      end
   end

   always_comb begin
      state_d    = FETCH;
      pc_update  = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      reg_write  = 1'b0;
      alu_op     = 2'b00;
      branch     = 1'b0;
      retire     = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         FETCH: begin
            ir_write   = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            pc_update  = 1'b1;
            state_d    = DECODE;
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (ctrl.op)
               7'b0000011, 7'b0100011: state_d = MEMADR;
               7'b0110011:             state_d = EXECUTER;
               7'b0010011:             state_d = EXECUTEI;
               7'b1100011:             state_d = BEQ;
               7'b1101111:             state_d = JAL;
               7'b0110111:             state_d = LUI;
               default:                state_d = ILLEGAL;
            endcase
         end
         MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = (ctrl.op == 7'b0000011) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            adr_src = 1'b1;
            state_d = (wait_q == WAIT_LAST) ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            retire     = 1'b1;
         end
         MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            retire    = 1'b1;
         end
         EXECUTER: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            state_d   = ALUWB;
         end
         EXECUTEI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
            state_d   = ALUWB;
         end
         ALUWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
         end
         BEQ: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            branch    = 1'b1;
            retire    = 1'b1;
         end
         JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
            state_d   = ALUWB;
         end
         LUI: begin
            alu_src_a = 2'b11;
            alu_src_b = 2'b01;
            state_d   = ALUWB;
         end
         ILLEGAL: begin
            illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            state_d = ILLEGAL;
`else
            retire  = 1'b1;
            state_d = FETCH;
`endif
         end
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      case (ctrl.op)
         7'b0000011, 7'b0010011: ctrl.ImmSrc = 3'b000;
         7'b0100011:             ctrl.ImmSrc = 3'b001;
         7'b1100011:             ctrl.ImmSrc = 3'b010;
         7'b1101111:             ctrl.ImmSrc = 3'b011;
         7'b0110111:             ctrl.ImmSrc = 3'b100;
         default:                ctrl.ImmSrc = 3'b000;
      endcase
   end

   // Write enables are gated by rst so nothing commits while reset is held.
   always_comb begin
      ctrl.PCWrite     = ~rst & (pc_update | (branch & ctrl.Zero));
      ctrl.IRWrite     = ~rst & ir_write;
      ctrl.MemWrite    = ~rst & mem_write;
      ctrl.RegWrite    = ~rst & reg_write;
      ctrl.InstrRetire = ~rst & retire;
      ctrl.AdrSrc      = adr_src;
      ctrl.ResultSrc   = result_src;
      ctrl.ALUSrcA     = alu_src_a;
      ctrl.ALUSrcB     = alu_src_b;
      ctrl.ALUOp       = alu_op;
      ctrl.Branch      = branch;
      ctrl.IllegalOp   = illegal;
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: two instances (MEM_WAIT 0 and 3) checked per cycle
// against a state-sequence/output-table model; the idle instance is held in reset.
module tb_multicycle_main_fsm;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   logic clk = 1'b0;
   logic rst_drv = 1'b1;
   logic sel = 1'b0;
   logic rst0, rst3;
   logic [3:0] st0, st3;
   logic [22:0] obs0, obs3, obs;
   int vectors = 0;
   int miscompares = 0;

   multicycle_main_fsm_if if0 ();
   multicycle_main_fsm_if if3 ();

   assign rst0 = rst_drv | sel;
   assign rst3 = rst_drv | ~sel;

   multicycle_main_fsm #(.MEM_WAIT(0), .STATE_W(4)) dut0 (.clk(clk), .rst(rst0), .ctrl(if0.master), .state(st0));
   multicycle_main_fsm #(.MEM_WAIT(3), .STATE_W(4)) dut3 (.clk(clk), .rst(rst3), .ctrl(if3.master), .state(st3));

   always #5 clk = ~clk;

   assign obs0 = {if0.PCWrite, if0.AdrSrc, if0.MemWrite, if0.IRWrite, if0.ResultSrc, if0.ALUSrcA,
                  if0.ALUSrcB, if0.ImmSrc, if0.RegWrite, if0.ALUOp, if0.Branch, if0.InstrRetire,
                  if0.IllegalOp, st0};
   assign obs3 = {if3.PCWrite, if3.AdrSrc, if3.MemWrite, if3.IRWrite, if3.ResultSrc, if3.ALUSrcA,
                  if3.ALUSrcB, if3.ImmSrc, if3.RegWrite, if3.ALUOp, if3.Branch, if3.InstrRetire,
                  if3.IllegalOp, st3};
   assign obs = sel ? obs3 : obs0;

   function automatic bit is_legal(input logic [6:0] o);
      return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
             (o == OP_BEQ) || (o == OP_JAL) || (o == OP_LUI);
   endfunction

   function automatic logic [2:0] imm_of(input logic [6:0] o);
      if (o == OP_LW || o == OP_I) return 3'b000;
      if (o == OP_SW)  return 3'b001;
      if (o == OP_BEQ) return 3'b010;
      if (o == OP_JAL) return 3'b011;
      if (o == OP_LUI) return 3'b100;
      return 3'b000;
   endfunction

   // Output table per named step, packed in the same field order as obs.
   function automatic logic [22:0] exp_out(input int s, input logic [6:0] o, input logic z, input bit in_rst);
      logic pcu, adr, memw, irw, rw, br, ret, ill;
      logic [1:0] rs, sa, sb, aop;
      pcu = 0; adr = 0; memw = 0; irw = 0; rw = 0; br = 0; ret = 0; ill = 0;
      rs = 0; sa = 0; sb = 0; aop = 0;
      case (s)
         0:  begin irw = 1; sb = 2'b10; rs = 2'b10; pcu = 1; end
         1:  begin sa = 2'b01; sb = 2'b01; end
         2:  begin sa = 2'b10; sb = 2'b01; end
         3:  begin adr = 1; end
         4:  begin rs = 2'b01; rw = 1; ret = 1; end
         5:  begin adr = 1; memw = 1; ret = 1; end
         6:  begin sa = 2'b10; aop = 2'b10; end
         7:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
         8:  begin rw = 1; ret = 1; end
         9:  begin sa = 2'b10; aop = 2'b01; br = 1; ret = 1; end
         10: begin sa = 2'b01; sb = 2'b10; pcu = 1; end
         11: begin sa = 2'b11; sb = 2'b01; end
         12: begin
            ill = 1;
`ifndef ILLEGAL_TRAP_EN
            ret = 1;
`endif
         end
         default: ;
      endcase
      if (in_rst) begin
         pcu = 0; irw = 0; memw = 0; rw = 0; ret = 0; br = 0;
      end
      return {pcu | (br & z), adr, memw, irw, rs, sa, sb, imm_of(o), rw, aop, br, ret, ill, 4'(s)};
   endfunction

   task automatic drive(input logic [6:0] o, input logic z);
      if0.op = o; if3.op = o; if0.Zero = z; if3.Zero = z;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_drv = 1'b1;
      #1;
      vectors++;
      if (obs !== exp_out(0, if0.op, if0.Zero, 1)) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs actual=%h required=%h", obs, exp_out(0, if0.op, if0.Zero, 1));
      end
      @(negedge clk);
      rst_drv = 1'b0;
   endtask

   // Runs one instruction from FETCH, checking every cycle. Starts and ends at a negedge.
   task automatic run_instr(input logic [6:0] o, input logic z, output int retires, output int mr_cycles);
      int seq[$];
      int mw;
      mw = sel ? 3 : 0;
      retires = 0;
      mr_cycles = 0;
      seq = {0, 1};
      if (o == OP_LW) begin
         seq.push_back(2);
         for (int k = 0; k <= mw; k++) seq.push_back(3);
         seq.push_back(4);
      end else if (o == OP_SW)  seq = {seq, 2, 5};
      else if (o == OP_R)       seq = {seq, 6, 8};
      else if (o == OP_I)       seq = {seq, 7, 8};
      else if (o == OP_BEQ)     seq.push_back(9);
      else if (o == OP_JAL)     seq = {seq, 10, 8};
      else if (o == OP_LUI)     seq = {seq, 11, 8};
      else begin
`ifdef ILLEGAL_TRAP_EN
         for (int k = 0; k < 20; k++) seq.push_back(12);
`else
         seq.push_back(12);
`endif
      end
      drive(o, z);
      foreach (seq[i]) begin
         #1;
         vectors++;
         if (obs !== exp_out(seq[i], o, z, 0)) begin
            miscompares++;
            $display("[TB] FAIL step op=%b step=%0d actual=%h required=%h", o, i, obs, exp_out(seq[i], o, z, 0));
         end
         if (obs[5]) retires++;
         if (obs[3:0] == 4'd3) mr_cycles++;
         @(negedge clk);
      end
`ifdef ILLEGAL_TRAP_EN
      if (!is_legal(o)) do_reset();
`endif
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_load();
      int r, m;
      run_instr(OP_LW, 1'b0, r, m);
      vectors++;
      if (r !== 1) begin
         miscompares++;
         $display("[TB] FAIL load_retire_count actual=%0d required=1", r);
      end
   endtask

   task automatic test_load_wait();
      int r, m;
      sel = 1'b1;
      do_reset();
      run_instr(OP_LW, 1'b1, r, m);
      vectors++;
      if (m !== 4) begin
         miscompares++;
         $display("[TB] FAIL memread_hold actual=%0d required=4", m);
      end
      sel = 1'b0;
      do_reset();
   endtask

   task automatic test_branch();
      int r, m;
      run_instr(OP_BEQ, 1'b1, r, m);
      run_instr(OP_BEQ, 1'b0, r, m);
   endtask

   task automatic test_jal();
      int r, m;
      run_instr(OP_JAL, 1'b0, r, m);
      run_instr(OP_LUI, 1'b1, r, m);
      run_instr(OP_R, 1'b0, r, m);
      run_instr(OP_I, 1'b0, r, m);
      run_instr(OP_SW, 1'b1, r, m);
   endtask

   task automatic test_illegal();
      int r, m;
      run_instr(7'b1111111, 1'b0, r, m);
      #1;
      vectors++;
      if (obs[3:0] !== 4'd0 || obs[4] !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL illegal_exit actual_state=%0d actual_ill=%b required_state=0 required_ill=0", obs[3:0], obs[4]);
      end
   endtask

   task automatic test_async_reset();
      drive(OP_SW, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      vectors++;
      if (obs[20] !== 1'b1 || obs[3:0] !== 4'd5) begin
         miscompares++;
         $display("[TB] FAIL reach_memwrite actual_state=%0d actual_memw=%b required_state=5 required_memw=1", obs[3:0], obs[20]);
      end
      #1 rst_drv = 1'b1;
      #1;
      vectors++;
      if (obs !== exp_out(0, OP_SW, 1'b0, 1)) begin
         miscompares++;
         $display("[TB] FAIL async_reset actual=%h required=%h", obs, exp_out(0, OP_SW, 1'b0, 1));
      end
      @(negedge clk);
      rst_drv = 1'b0;
      #1;
      vectors++;
      if (obs !== exp_out(0, OP_SW, 1'b0, 0)) begin
         miscompares++;
         $display("[TB] FAIL post_reset_fetch actual=%h required=%h", obs, exp_out(0, OP_SW, 1'b0, 0));
      end
      do_reset();
   endtask

   task automatic test_random();
      logic [6:0] pool[7];
      logic [6:0] o;
      int r, m;
      pool = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_LUI};
      for (int n = 0; n < 60; n++) begin
         if (n == 40) begin
            sel = 1'b1;
            do_reset();
         end
         if ($urandom_range(0, 9) == 0) begin
            o = 7'b1111111;
            for (int t = 0; t < 16; t++) begin
               o = 7'($urandom_range(0, 127));
               if (!is_legal(o)) break;
            end
            if (is_legal(o)) o = 7'b0000000;
         end else begin
            o = pool[$urandom_range(0, 6)];
         end
         run_instr(o, 1'($urandom_range(0, 1)), r, m);
      end
      sel = 1'b0;
      do_reset();
   endtask

   initial begin
      drive(OP_LW, 1'b0);
      test_reset();
      test_load();
      test_load_wait();
      test_branch();
      test_jal();
      test_illegal();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
